// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide engine: opcodes, FSM states,
// and opcode classification helpers.
package ex_muldiv_unit_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

  localparam int DEF_WIDTH = 32;

  function automatic logic is_signed_op(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic is_div_op(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_step_dp.sv
// Accumulator datapath: one shift-add multiply step or one restoring
// shift-subtract divide step per enabled cycle, on unsigned magnitudes.
module ex_muldiv_unit_step_dp #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] lo_init_i,
  input  logic [WIDTH-1:0] b_init_i,
  output logic [WIDTH-1:0] acc_hi_o,
  output logic [WIDTH-1:0] acc_lo_o
);

  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   addsub_a;
  logic [WIDTH:0]   addsub;
  logic             ge;

  // One WIDTH+1 adder serves both ops; the extra bit keeps the unsigned multiply carry.
  assign rem_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign addsub_a = is_div_i ? rem_sh : {1'b0, acc_hi_q};
  assign addsub   = is_div_i ? (addsub_a - {1'b0, b_q}) : (addsub_a + {1'b0, b_q});
  assign ge       = rem_sh >= {1'b0, b_q};

  always_comb begin
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    b_d      = b_q;
    if (load_i) begin
      acc_hi_d = '0;
      acc_lo_d = lo_init_i;
      b_d      = b_init_i;
    end else if (step_i) begin
      if (is_div_i) begin
        if (ge) begin
          acc_hi_d = addsub[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_hi_d = rem_sh[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
        end
      end else if (acc_lo_q[0]) begin
        acc_hi_d = addsub[WIDTH:1];
        acc_lo_d = {addsub[0], acc_lo_q[WIDTH-1:1]};
      end else begin
        acc_hi_d = {1'b0, acc_hi_q[WIDTH-1:1]};
        acc_lo_d = {acc_hi_q[0], acc_lo_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      b_q      <= '0;
    end else begin
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      b_q      <= b_d;
    end
  end

  assign acc_hi_o = acc_hi_q;
  assign acc_lo_o = acc_lo_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine for the EX stage; stalls the front of the
// pipe while busy and presents a sign-corrected HI/LO pair with a one-cycle done.
//
// state  | meaning
// S_IDLE | waiting for start; stall follows start combinationally
// S_BUSY | one datapath step per cycle, ITERS steps total
// S_DONE | hi/lo valid, done pulse, pipeline released
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ITERS = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs_val_i,
  input  logic [WIDTH-1:0] rt_val_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  op_e              op_q;
  logic             neg_a_q, neg_b_q, dz_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  op_e              op_in;
  logic             sgn_in, load, step, last_step;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] acc_hi, acc_lo;
  logic [WIDTH-1:0] res_hi, res_lo;

  assign op_in     = op_e'(op_i);
  assign sgn_in    = is_signed_op(op_in);
  assign a_mag     = (sgn_in && rs_val_i[WIDTH-1]) ? -rs_val_i : rs_val_i;
  assign b_mag     = (sgn_in && rt_val_i[WIDTH-1]) ? -rt_val_i : rt_val_i;
  assign load      = (state_q == S_IDLE) && start_i && !flush_i;
  assign step      = (state_q == S_BUSY) && !flush_i;
  assign last_step = (count_q == CW'(ITERS - 1));

  ex_muldiv_unit_step_dp #(.WIDTH(WIDTH)) u_dp (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (load),
    .step_i    (step),
    .is_div_i  (is_div_op(op_q)),
    .lo_init_i (is_div_op(op_in) ? a_mag : b_mag),
    .b_init_i  (is_div_op(op_in) ? b_mag : a_mag),
    .acc_hi_o  (acc_hi),
    .acc_lo_o  (acc_lo)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start_i) state_d = S_BUSY;
        S_BUSY:  if (last_step) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    stall_o = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      S_IDLE:  stall_o = start_i && !flush_i;
      S_BUSY:  stall_o = 1'b1;
      S_DONE:  done_o  = !flush_i;
      default: ;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (state_q == S_BUSY) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      op_q    <= OP_MULT;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      if (load) begin
        op_q    <= op_in;
        neg_a_q <= sgn_in & rs_val_i[WIDTH-1];
        neg_b_q <= sgn_in & rt_val_i[WIDTH-1];
        dz_q    <= (rt_val_i == '0);
      end
    end
  end

  // Divide-by-zero keeps the all-ones quotient; the remainder correction restores rs_val.
  always_comb begin
    res_hi = acc_hi;
    res_lo = acc_lo;
    if (is_div_op(op_q)) begin
      if (is_signed_op(op_q) && (neg_a_q ^ neg_b_q) && !dz_q) res_lo = -acc_lo;
      if (is_signed_op(op_q) && neg_a_q) res_hi = -acc_hi;
    end else if (is_signed_op(op_q) && (neg_a_q ^ neg_b_q)) begin
      {res_hi, res_lo} = -{acc_hi, acc_lo};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (done_o) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end
  end

  assign hi_o = done_o ? res_hi : hi_q;
  assign lo_o = done_o ? res_lo : lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed corner cases plus randomized ops
// checked against a plain-arithmetic reference model.
module tb_ex_muldiv_unit;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  logic        clk = 1'b0;
  logic        rst, flush, start;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        stall, done;
  logic [31:0] hi, lo;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] sb_q[$];
  logic [31:0] last_hi = 32'h0, last_lo = 32'h0;

  ex_muldiv_unit #(.WIDTH(32), .ITERS(32)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .flush_i  (flush),
    .start_i  (start),
    .op_i     (op),
    .rs_val_i (rs_val),
    .rt_val_i (rt_val),
    .stall_o  (stall),
    .done_o   (done),
    .hi_o     (hi),
    .lo_o     (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Result as {hi, lo}, straight from the arithmetic definition of each op.
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint p;
    int     sa, sb, q, r;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      MULT: begin
        p = longint'(sa) * longint'(sb);
        return p;
      end
      MULTU: return {32'h0, a} * {32'h0, b};
      DIV: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      4: return -$urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        check("result_hi", hi, e[63:32]);
        check("result_lo", lo, e[31:0]);
      end
    end
  end

  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    #1;
    check("stall_on_start", stall, 1'b1);
    @(posedge clk);
    #1;
    start  = 1'b0;
    op     = 2'($urandom);
    rs_val = $urandom;
    rt_val = $urandom;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    int          k;
    bit          got, stall_ok;
    e = ref_model(o, a, b);
    sb_q.push_back(e);
    start_op(o, a, b);
    k = 0;
    got = 0;
    stall_ok = 1;
    while (k < 40 && !got) begin
      @(negedge clk);
      k++;
      if (done === 1'b1) got = 1;
      else begin
        if (stall !== 1'b1) stall_ok = 0;
        start  = 1'($urandom_range(0, 1));
        rs_val = $urandom;
        rt_val = $urandom;
      end
    end
    start = 1'b0;
    check("done_seen", got, 1'b1);
    if (got) begin
      check("latency", k, 33);
      check("stall_busy", stall_ok, 1'b1);
      check("stall_done_low", stall, 1'b0);
      last_hi = e[63:32];
      last_lo = e[31:0];
    end else begin
      void'(sb_q.pop_back());
    end
  endtask

  task automatic hold_check();
    @(negedge clk);
    check("hold_hi", hi, last_hi);
    check("hold_lo", lo, last_lo);
    check("idle_done_low", done, 1'b0);
  endtask

  task automatic no_done_window(input string name, input int cycles);
    bit seen;
    seen = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    check(name, seen, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; start = 1'b0; op = MULT; rs_val = '0; rt_val = '0;
    repeat (3) @(negedge clk);
    check("rst_stall", stall, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    rst = 1'b0;

    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    hold_check();
    run_op(MULT, -32'sd3, 32'd7);
    run_op(MULT, 32'h8000_0000, 32'h8000_0000);
    run_op(DIV, -32'sd7, 32'd2);
    run_op(DIVU, 32'd7, 32'd2);
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(DIVU, 32'd100, 32'd0);
    run_op(DIV, -32'sd5, 32'd0);
    hold_check();

    // Abort a divide mid-flight; the previous result must survive.
    start_op(DIV, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_stall_low", stall, 1'b0);
    check("flush_hi_kept", hi, last_hi);
    check("flush_lo_kept", lo, last_lo);
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = MULTU; rs_val = 32'd3; rt_val = 32'd4;
    #1 check("flush_start_stall", stall, 1'b0);
    @(posedge clk);
    #1 begin start = 1'b0; flush = 1'b0; end
    no_done_window("no_done_after_flush", 40);
    run_op(DIV, 32'd1000, 32'd7);

    // Synchronous reset in the middle of a multiply.
    start_op(MULT, 32'h1234_5678, -32'sd9);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_stall", stall, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_hi", hi, 32'h0);
    check("midrst_lo", lo, 32'h0);
    rst = 1'b0;
    last_hi = 32'h0;
    last_lo = 32'h0;
    no_done_window("no_done_after_rst", 40);
    run_op(MULT, 32'h1234_5678, -32'sd9);

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom), rand_val(), rand_val());
      if ($urandom_range(0, 3) == 0) hold_check();
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
